// File: rtl/part2_in_debounce_if.sv
// Bus bundle for the five-channel input conditioner (raw levels in, clean levels/pulses/flags out).
// Optional evt_cnt member is present only when PART2_DEBOUNCE_EVT_CNT_EN is defined.
interface part2_in_debounce_if;
  logic [4:0] raw_in;
  logic [4:0] chg_ack;
  logic [4:0] db_out;
  logic [4:0] rise_pulse;
  logic [4:0] fall_pulse;
  logic [4:0] change_flag;
`ifdef PART2_DEBOUNCE_EVT_CNT_EN
  logic [7:0] evt_cnt;

  modport master (output raw_in, chg_ack,
                  input  db_out, rise_pulse, fall_pulse, change_flag, evt_cnt);
  modport slave  (input  raw_in, chg_ack,
                  output db_out, rise_pulse, fall_pulse, change_flag, evt_cnt);
`else
  modport master (output raw_in, chg_ack,
                  input  db_out, rise_pulse, fall_pulse, change_flag);
  modport slave  (input  raw_in, chg_ack,
                  output db_out, rise_pulse, fall_pulse, change_flag);
`endif
endinterface

// File: rtl/part2_in_debounce.sv
// Five-channel synchroniser + debouncer feeding the inverter stage channels A..E.
// Optional transition event counter enabled by PART2_DEBOUNCE_EVT_CNT_EN.
module part2_in_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 8,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  part2_in_debounce_if.slave   bus
);

  localparam bit PARAM_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                            (DEBOUNCE >= 1) && (DEBOUNCE <= (2**CNT_W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  generate
    if (!PARAM_OK) begin : g_param_err
      initial begin
        $display("ERROR: part2_in_debounce illegal parameters SYNC_STAGES=%0d DEBOUNCE=%0d CNT_W=%0d",
                 SYNC_STAGES, DEBOUNCE, CNT_W);
        $finish;
      end
    end
  endgenerate

  logic [4:0]       sync_r [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_r [5];
  logic [CNT_W-1:0] cnt_nxt_s [5];
  logic [4:0]       s_s;
  logic [4:0]       upd_s;
  logic [4:0]       db_r;
  logic [4:0]       rise_r;
  logic [4:0]       fall_r;
  logic [4:0]       flag_r;

  // synchroniser shift chain, last stage feeds the debouncer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= 5'b00000;
    end else begin
      sync_r[0] <= bus.raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // per-channel stability counter: any agreement with db_out restarts the count
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      upd_s[i]     = 1'b0;
      cnt_nxt_s[i] = cnt_r[i];
      if (s_s[i] == db_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_MAX) begin
        upd_s[i]     = 1'b1;
        cnt_nxt_s[i] = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // debounced state, edge pulses and sticky flags; a set on the ack edge wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) cnt_r[i] <= CNT_ZERO;
      db_r   <= 5'b00000;
      rise_r <= 5'b00000;
      fall_r <= 5'b00000;
      flag_r <= 5'b00000;
    end else begin
      for (int i = 0; i < 5; i++) cnt_r[i] <= cnt_nxt_s[i];
      db_r   <= db_r ^ upd_s;
      rise_r <= upd_s & ~db_r;
      fall_r <= upd_s & db_r;
      flag_r <= (flag_r & ~bus.chg_ack) | upd_s;
    end
  end

  assign bus.db_out      = db_r;
  assign bus.rise_pulse  = rise_r;
  assign bus.fall_pulse  = fall_r;
  assign bus.change_flag = flag_r;

`ifdef PART2_DEBOUNCE_EVT_CNT_EN
  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    logic [2:0] sum;
    sum = 3'd0;
    for (int k = 0; k < 5; k++) sum = sum + {2'b00, v[k]};
    return sum;
  endfunction

  logic [7:0] evt_r;

  // counts pulses visible this cycle, wraps modulo 256
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_r <= 8'd0;
    end else begin
      evt_r <= evt_r + {5'b00000, popcnt5(rise_r | fall_r)};
    end
  end

  assign bus.evt_cnt = evt_r;
`endif

endmodule

// File: tb/tb_part2_in_debounce.sv
// Bench for part2_in_debounce: directed scenarios plus randomized traffic against a
// window-based reference model (level must differ from db_out for DEBOUNCE consecutive edges).
module tb_part2_in_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 8;

  logic clk;
  logic rst;
  part2_in_debounce_if bus ();

  part2_in_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // reference model state
  logic [4:0] raw_q [$];
  logic [4:0] s_q [$];
  logic [4:0] m_db, m_rise, m_fall, m_flag;
  logic [7:0] m_evt;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [4:0] r, input logic [4:0] a, input logic rs);
    logic [4:0] s, upd;
    bit all_diff;
    if (rs) begin
      raw_q.delete();
      s_q.delete();
      m_db = 5'd0; m_rise = 5'd0; m_fall = 5'd0; m_flag = 5'd0; m_evt = 8'd0;
    end else begin
      m_evt = m_evt + 8'($countones(m_rise | m_fall));
      s = (raw_q.size() >= SYNC) ? raw_q[raw_q.size() - SYNC] : 5'd0;
      s_q.push_back(s);
      if (s_q.size() > DEB) void'(s_q.pop_front());
      upd = 5'd0;
      if (s_q.size() == DEB) begin
        for (int ch = 0; ch < 5; ch++) begin
          all_diff = 1'b1;
          foreach (s_q[k]) if (s_q[k][ch] == m_db[ch]) all_diff = 1'b0;
          upd[ch] = all_diff;
        end
      end
      m_rise = upd & ~m_db;
      m_fall = upd & m_db;
      m_db   = m_db ^ upd;
      m_flag = (m_flag & ~a) | upd;
      raw_q.push_back(r);
      if (raw_q.size() > 8) void'(raw_q.pop_front());
    end
  endtask

  task automatic step(input logic [4:0] r, input logic [4:0] a, input logic rs);
    bus.raw_in  = r;
    bus.chg_ack = a;
    rst         = rs;
    @(posedge clk);
    model(r, a, rs);
    @(negedge clk);
    chk("db_out",      {3'b000, bus.db_out},      {3'b000, m_db});
    chk("rise_pulse",  {3'b000, bus.rise_pulse},  {3'b000, m_rise});
    chk("fall_pulse",  {3'b000, bus.fall_pulse},  {3'b000, m_fall});
    chk("change_flag", {3'b000, bus.change_flag}, {3'b000, m_flag});
`ifdef PART2_DEBOUNCE_EVT_CNT_EN
    chk("evt_cnt", bus.evt_cnt, m_evt);
`endif
  endtask

  initial begin
    logic [4:0] r, a;
    int hold;
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    rst         = 1'b1;
    bus.raw_in  = 5'h00;
    bus.chg_ack = 5'h00;
    @(negedge clk);

    // reset held with all inputs high, then release and re-debounce
    for (int i = 0; i < 3; i++) begin
      step(5'h1F, 5'h00, 1'b1);
      chk("rst_db", {3'b000, bus.db_out}, 8'h00);
      chk("rst_rise", {3'b000, bus.rise_pulse}, 8'h00);
    end
    for (int i = 1; i <= 12; i++) begin
      step(5'h1F, 5'h00, 1'b0);
      chk("t1_rise", {3'b000, bus.rise_pulse}, (i == 10) ? 8'h1F : 8'h00);
      chk("t1_db", {3'b000, bus.db_out}, (i >= 10) ? 8'h1F : 8'h00);
    end
    chk("t1_flag", {3'b000, bus.change_flag}, 8'h1F);

    // ch1 falls while ack held: set wins on the update edge, ack clears next edge
    for (int i = 1; i <= 10; i++) begin
      step(5'h1D, 5'h02, 1'b0);
      chk("t4_fall1", {7'd0, bus.fall_pulse[1]}, (i == 10) ? 8'h01 : 8'h00);
    end
    chk("t4_flag_set_wins", {7'd0, bus.change_flag[1]}, 8'h01);
    step(5'h1D, 5'h02, 1'b0);
    chk("t4_flag_cleared", {7'd0, bus.change_flag[1]}, 8'h00);

    for (int i = 0; i < 12; i++) step(5'h00, 5'h1F, 1'b0);

    // short pulse on ch0 is rejected
    for (int i = 0; i < 5; i++) step(5'h01, 5'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(5'h00, 5'h00, 1'b0);
      chk("t2_db0", {7'd0, bus.db_out[0]}, 8'h00);
      chk("t2_flag0", {7'd0, bus.change_flag[0]}, 8'h00);
    end

    // staggered rises on ch2 and ch4
    for (int i = 1; i <= 16; i++) begin
      step((i >= 4) ? 5'h14 : 5'h04, 5'h00, 1'b0);
      chk("t3_rise2", {7'd0, bus.rise_pulse[2]}, (i == 10) ? 8'h01 : 8'h00);
      chk("t3_rise4", {7'd0, bus.rise_pulse[4]}, (i == 13) ? 8'h01 : 8'h00);
    end

    // reset mid-count on ch3, then full re-debounce
    for (int i = 0; i < 8; i++) step(5'h1C, 5'h00, 1'b0);
    step(5'h1C, 5'h00, 1'b1);
    chk("t5_rst_db", {3'b000, bus.db_out}, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      step(5'h1C, 5'h00, 1'b0);
      chk("t5_rise3", {7'd0, bus.rise_pulse[3]}, (i == 10) ? 8'h01 : 8'h00);
      chk("t5_db3", {7'd0, bus.db_out[3]}, (i >= 10) ? 8'h01 : 8'h00);
    end

    // randomized traffic: mixed hold lengths give both glitches and clean transitions
    for (int seg = 0; seg < 200; seg++) begin
      r    = 5'($urandom);
      hold = (seg % 4 == 0) ? 12 : int'($urandom_range(1, 14));
      for (int h = 0; h < hold; h++) begin
        a = 5'($urandom) & 5'($urandom);
        step(r, a, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
